// File: rtl/register_sequencer_pkg.sv
// Shared encodings for the register-file sequencer: register op codes,
// instruction opcodes, ALU functions and FSM states.
package register_sequencer_pkg;

    localparam int unsigned REG_OP_W = 2;
    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned ALU_OP_W = 2;

    // Datapath register operations
    localparam logic [REG_OP_W-1:0] REG_CLEAR  = 2'b00;
    localparam logic [REG_OP_W-1:0] REG_LOAD   = 2'b01;
    localparam logic [REG_OP_W-1:0] REG_HOLD   = 2'b10;
    localparam logic [REG_OP_W-1:0] REG_SHIFTL = 2'b11;

    // ALU functions; encoding 2'b11 is never driven
    localparam logic [ALU_OP_W-1:0] ALU_A_PLUS_B  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_A_MINUS_B = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_R_PLUS_A  = 2'b10;

    typedef enum logic [OPCODE_W-1:0] {
        OPC_NOP = 3'b000,
        OPC_LDA = 3'b001,
        OPC_LDB = 3'b010,
        OPC_ADD = 3'b011,
        OPC_SUB = 3'b100,
        OPC_MUL = 3'b101,
        OPC_CLR = 3'b110,
        OPC_SHR = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_MUL_SHIFT = 3'd2,
        S_MUL_ADD   = 3'd3,
        S_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/register_sequencer.sv
// Instruction sequencer for the 4-bit A/B/R register file: decodes an opcode
// into per-register op codes and ALU controls, including shift-add multiply.
module register_sequencer
    import register_sequencer_pkg::*;
#(
    parameter int unsigned MUL_STEPS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       b_msb,
    output logic [1:0] op_a,
    output logic [1:0] op_b,
    output logic [1:0] op_r,
    output logic       sel_a,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    state_e           state_q, state_d;
    opcode_e          opc_q, opc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, latched instruction and multiply iteration counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            opc_q   <= OPC_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control decode; outputs follow state so reset idles them at once
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        op_a    = REG_HOLD;
        op_b    = REG_HOLD;
        op_r    = REG_HOLD;
        sel_a   = 1'b0;
        alu_op  = ALU_A_PLUS_B;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    opc_d   = opcode_e'(opcode);
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_DONE;
                case (opc_q)
                    OPC_NOP: ;
                    OPC_LDA: begin
                        op_a  = REG_LOAD;
                        sel_a = 1'b0;
                    end
                    OPC_LDB: op_b = REG_LOAD;
                    OPC_ADD: begin
                        op_r   = REG_LOAD;
                        alu_op = ALU_A_PLUS_B;
                    end
                    OPC_SUB: begin
                        op_r   = REG_LOAD;
                        alu_op = ALU_A_MINUS_B;
                    end
                    OPC_MUL: begin
                        op_r    = REG_CLEAR;
                        cnt_d   = '0;
                        state_d = S_MUL_SHIFT;
                    end
                    OPC_CLR: begin
                        op_a = REG_CLEAR;
                        op_b = REG_CLEAR;
                        op_r = REG_CLEAR;
                    end
                    OPC_SHR: op_r = REG_SHIFTL;
                    default: ;
                endcase
            end

            S_MUL_SHIFT: begin
                op_r    = REG_SHIFTL;
                state_d = S_MUL_ADD;
            end

            // Multiplier consumed MSB-first: B shifts left as R accumulates
            S_MUL_ADD: begin
                alu_op = ALU_R_PLUS_A;
                op_b   = REG_SHIFTL;
                op_r   = b_msb ? REG_LOAD : REG_HOLD;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_MUL_SHIFT;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench for register_sequencer with a behavioural A/B/R register
// file and ALU model closing the b_msb loop.
module tb_register_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] opcode;
    logic       b_msb;
    logic [1:0] op_a, op_b, op_r;
    logic       sel_a;
    logic [1:0] alu_op;
    logic       busy, done;

    logic [3:0] din;
    logic [3:0] m_a, m_b, m_r;
    logic [3:0] alu_res;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_sequencer #(.MUL_STEPS(4)) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .start  (start),
        .opcode (opcode),
        .b_msb  (b_msb),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_r   (op_r),
        .sel_a  (sel_a),
        .alu_op (alu_op),
        .busy   (busy),
        .done   (done)
    );

    // Datapath model: 4-bit registers, modulo-16 ALU
    assign b_msb = m_b[3];

    always_comb begin
        case (alu_op)
            2'b00:   alu_res = m_a + m_b;
            2'b01:   alu_res = m_a - m_b;
            2'b10:   alu_res = m_r + m_a;
            default: alu_res = 4'h0;
        endcase
    end

    always @(posedge clk) begin
        case (op_a)
            2'b00: m_a <= 4'h0;
            2'b01: m_a <= sel_a ? alu_res : din;
            2'b11: m_a <= {m_a[2:0], 1'b0};
            default: ;
        endcase
        case (op_b)
            2'b00: m_b <= 4'h0;
            2'b01: m_b <= din;
            2'b11: m_b <= {m_b[2:0], 1'b0};
            default: ;
        endcase
        case (op_r)
            2'b00: m_r <= 4'h0;
            2'b01: m_r <= alu_res;
            2'b11: m_r <= {m_r[2:0], 1'b0};
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a single-cycle instruction from IDLE and check EXEC, DONE and return to IDLE
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] d,
                          input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] er,
                          input logic [1:0] ealu);
        @(negedge clk);
        start = 1'b1; opcode = op; din = d;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
        chk({tag, "_op_a"}, 32'(op_a), 32'(ea));
        chk({tag, "_op_b"}, 32'(op_b), 32'(eb));
        chk({tag, "_op_r"}, 32'(op_r), 32'(er));
        chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(ealu));
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_ops"}, 32'({op_a, op_b, op_r}), 32'h2A);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    // Issue MUL; report done latency, done-pulse count and op_r per MUL_ADD iteration
    task automatic run_mul(output int lat, output int ndone, output logic [7:0] pat);
        int idx;
        @(negedge clk);
        start = 1'b1; opcode = 3'b101; din = 4'h0;
        lat = 0; ndone = 0; pat = 8'h00; idx = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (alu_op == 2'b10 && idx < 4) begin
                pat[2*idx +: 2] = op_r;
                idx++;
            end
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
    endtask

    int         lat, ndone, nbusy;
    logic [7:0] pat;
    logic [3:0] snap_a, snap_b, snap_r;

    initial begin
        reset_n = 1'b0; start = 1'b0; opcode = 3'b000; din = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ops", 32'({op_a, op_b, op_r}), 32'h2A);
        chk("rst_alu", 32'(alu_op), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ops", 32'({op_a, op_b, op_r}), 32'h2A);
        chk("idle_alu", 32'(alu_op), 32'd0);
        chk("idle_sel", 32'(sel_a), 32'd0);

        run_op("clr0", 3'b110, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        run_op("lda3", 3'b001, 4'h3, 2'b01, 2'b10, 2'b10, 2'b00);
        run_op("ldb5", 3'b010, 4'h5, 2'b10, 2'b01, 2'b10, 2'b00);
        chk("ab_loaded", 32'({m_a, m_b}), 32'h35);
        run_op("add", 3'b011, 4'h0, 2'b10, 2'b10, 2'b01, 2'b00);
        chk("add_r", 32'(m_r), 32'd8);
        run_op("sub", 3'b100, 4'h0, 2'b10, 2'b10, 2'b01, 2'b01);
        chk("sub_r", 32'(m_r), 32'd14);
        run_op("shr", 3'b111, 4'h0, 2'b10, 2'b10, 2'b11, 2'b00);
        chk("shr_r", 32'(m_r), 32'd12);
        run_op("nop", 3'b000, 4'h0, 2'b10, 2'b10, 2'b10, 2'b00);
        chk("nop_r", 32'(m_r), 32'd12);

        // 3 * 5 = 15
        run_mul(lat, ndone, pat);
        chk("mul1_latency", 32'(lat), 32'd10);
        chk("mul1_ndone", 32'(ndone), 32'd1);
        chk("mul1_op_r_pattern", 32'(pat), 32'h66);
        chk("mul1_r", 32'(m_r), 32'd15);
        chk("mul1_busy_after", 32'(busy), 32'd0);

        // 5 * 4 = 20 mod 16 = 4
        run_op("lda5", 3'b001, 4'h5, 2'b01, 2'b10, 2'b10, 2'b00);
        run_op("ldb4", 3'b010, 4'h4, 2'b10, 2'b01, 2'b10, 2'b00);
        run_mul(lat, ndone, pat);
        chk("mul2_latency", 32'(lat), 32'd10);
        chk("mul2_ndone", 32'(ndone), 32'd1);
        chk("mul2_op_r_pattern", 32'(pat), 32'hA6);
        chk("mul2_r", 32'(m_r), 32'd4);

        // start held high through ADD; second opcode only taken in IDLE after DONE
        run_op("ldb2", 3'b010, 4'h2, 2'b10, 2'b01, 2'b10, 2'b00);
        @(negedge clk);
        start = 1'b1; opcode = 3'b011; din = 4'h9;
        @(negedge clk);
        chk("hold_exec_op_r", 32'(op_r), 32'd1);
        chk("hold_exec_op_b", 32'(op_b), 32'd2);
        opcode = 3'b010;
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_done_op_b", 32'(op_b), 32'd2);
        @(negedge clk);
        chk("hold_idle_busy", 32'(busy), 32'd0);
        chk("hold_add_r", 32'(m_r), 32'd7);
        @(negedge clk);
        start = 1'b0;
        chk("hold_second_op_b", 32'(op_b), 32'd1);
        chk("hold_second_op_r", 32'(op_r), 32'd2);
        @(negedge clk);
        chk("hold_second_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("hold_b", 32'(m_b), 32'd9);
        chk("hold_idle2_busy", 32'(busy), 32'd0);

        // Reset during MUL_ADD of iteration 2, with start asserted during reset
        @(negedge clk);
        start = 1'b1; opcode = 3'b101; din = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rstmul_in_add", 32'(alu_op), 32'd2);
        #2;
        reset_n = 1'b0; start = 1'b1; opcode = 3'b001; din = 4'h7;
        #1;
        chk("rstmul_busy", 32'(busy), 32'd0);
        chk("rstmul_ops", 32'({op_a, op_b, op_r}), 32'h2A);
        chk("rstmul_alu", 32'(alu_op), 32'd0);
        chk("rstmul_done", 32'(done), 32'd0);
        snap_a = m_a; snap_b = m_b; snap_r = m_r;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; start = 1'b0;
        ndone = 0; nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("rstmul_no_done", 32'(ndone), 32'd0);
        chk("rstmul_nothing_latched", 32'(nbusy), 32'd0);
        chk("rstmul_regs_kept", 32'({m_a, m_b, m_r}), 32'({snap_a, snap_b, snap_r}));

        run_op("clr1", 3'b110, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("clr1_regs", 32'({m_a, m_b, m_r}), 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
Name: register_sequencer

Overview:
- Control-side counterpart of the 4-bit register file: decodes a 3-bit instruction and drives the 2-bit operation code of each of three 4-bit registers: A (accumulator), B (operand), R (result).
- Also drives the ALU function and the A-input mux, and sequences multi-cycle instructions.
- Multiply is shift-add, using the registers' SHIFTL operation.
- Sits between the instruction source (front panel or program ROM) and the datapath.

Parameters:
- MUL_STEPS, 4, number of shift-add iterations for MUL (equals register width).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to execute opcode; sampled only when busy=0.
- opcode  in  3  instruction, captured on the accepting edge.
- b_msb  in  1  bit 3 of register B (multiplier MSB).
- op_a  out  2  operation code for register A.
- op_b  out  2  operation code for register B.
- op_r  out  2  operation code for register R.
- sel_a  out  1  A input mux: 0 = external data, 1 = ALU result.
- alu_op  out  2  ALU function: 00 = A+B, 01 = A-B, 10 = R+A, 11 unused.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Register op codes: CLEAR=00, LOAD=01, HOLD=10, SHIFTL=11.
- Opcodes and their EXEC actions:
  - 000 NOP: nothing.
  - 001 LDA: op_a=LOAD, sel_a=0.
  - 010 LDB: op_b=LOAD.
  - 011 ADD: op_r=LOAD, alu_op=00.
  - 100 SUB: op_r=LOAD, alu_op=01.
  - 101 MUL: multi-cycle, see below.
  - 110 CLR: op_a, op_b, op_r all CLEAR.
  - 111 SHR: op_r=SHIFTL.
- States: IDLE, EXEC, MUL_SHIFT, MUL_ADD, DONE. The state register and 2-bit iteration counter are flops; outputs are decoded from state, latched opcode and b_msb.
- Default outputs in any state and field not listed: op_a/op_b/op_r=HOLD, sel_a=0, alu_op=00, done=0.
- IDLE:
  - busy=0.
  - start=1 latches opcode and goes to EXEC.
  - start=0 stays in IDLE.
- EXEC:
  - Drives the single-cycle actions above for exactly one cycle.
  - Next state is DONE, except MUL.
  - MUL in EXEC: op_r=CLEAR, counter<=0, next state MUL_SHIFT.
- MUL_SHIFT: op_r=SHIFTL, op_b=HOLD; next state MUL_ADD.
- MUL_ADD:
  - alu_op=10; op_b=SHIFTL.
  - op_r=LOAD if b_msb=1, else HOLD.
  - If counter==MUL_STEPS-1, go to DONE; else counter+1 and go to MUL_SHIFT.
- DONE: done=1, all ops HOLD; next state IDLE.
- Latency from the accepting edge to the done cycle:
  - Single-cycle instructions: 2 cycles.
  - MUL: 2+2*MUL_STEPS = 10 cycles.
- Back-to-back: start may be re-asserted in the cycle after DONE (IDLE), giving one instruction per 3 cycles at best.
- start while busy=1 is ignored. No queuing, and opcode changes are not seen.
- MUL arithmetic is modulo 16: upper product bits are lost and no overflow flag is produced.
- Reset:
  - reset_n=0 immediately forces IDLE, counter=0, latched opcode=000.
  - All outputs go to their defaults, busy=0.
  - Reset mid-instruction abandons it; datapath registers see HOLD and keep their contents.
- reset_n low and start high together: reset wins and nothing is latched.
- The sequencer never drives alu_op=11.

Decomposition:
- Shared package holds:
  - register op-code constants: CLEAR, LOAD, HOLD, SHIFTL;
  - opcode constants: NOP, LDA, LDB, ADD, SUB, MUL, CLR, SHR;
  - ALU function constants;
  - state encoding.
- No sub-module needed. The iteration counter is small enough to stay inline.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, op_a/op_b/op_r=10, alu_op=00.
- start=1, opcode=011 -> EXEC cycle shows op_r=01 and alu_op=00; next cycle done=1; following cycle busy=0.
- With b_msb driven from a B=4'b0101 register model, A=3, issue MUL -> b_msb pattern 0,1,0,1 gives op_r LOAD in iterations 2 and 4; R=15 at done, 10 cycles after accept.
- MUL with A=5, B=4 -> R=20 mod 16 = 4; done pulses exactly once.
- start held high through an ADD -> no second instruction latched until the IDLE cycle after DONE; the second opcode executes then.
- reset_n pulsed low during MUL_ADD (iteration 2) -> outputs go to HOLD/idle defaults asynchronously and no done pulse follows; after release, a fresh CLR gives op_a=op_b=op_r=00 for one cycle.
